dice_roller: RTL and testbench

Pseudo-random dice generator for game/demo logic. On each rising edge of `roll` it produces a uniformly distributed face value for the die chosen by `die_select`: d4, d6, d8 or d20. The result is held on `rolled_number` until the next roll. The randomness source is a free-running 16-bit LFSR, so the block is fully synchronous, deterministic after reset, and needs no external entropy.

---
 rtl/dice_roller.sv | 80 ++++++++
 tb/tb_dice_roller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// dice_roller: pseudo-random d4/d6/d8/d20 generator.
// A free-running 16-bit Galois LFSR is sampled on each rising edge of `roll`.
// The sample is reduced modulo the selected die size and offset by one, so
// the registered face value always lies in 1..N.
// Reset is synchronous and active-high, even though the port is named rst_n.
module dice_roller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] die_select,
    input  logic       roll,
    output logic [7:0] rolled_number
);

    localparam logic [15:0] SEED = 16'hACE1;
    // Toggle mask for x^16 + x^14 + x^13 + x^11 + 1 in right-shifting form.
    localparam logic [15:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {
        DIE_D4  = 2'b00,
        DIE_D6  = 2'b01,
        DIE_D8  = 2'b10,
        DIE_D20 = 2'b11
    } die_e;

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic        roll_q;
    logic        roll_event;
    logic [7:0]  face;

    // Next LFSR state: a right shift with the mask applied when bit 0 falls out.
    // The all-zero state would lock up, so it is forced back to the seed.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so that no path
        // leaves it unassigned and infers a latch.
        lfsr_next = lfsr >> 1;
        if (lfsr == 16'h0000) begin
            lfsr_next = SEED;
        end else if (lfsr[0]) begin
            lfsr_next = (lfsr >> 1) ^ TAPS;
        end
    end

    // A roll is the rising edge of the `roll` level.
    assign roll_event = roll & ~roll_q;

    // Face value from the pre-shift LFSR sample. The divisors are constants, so
    // each branch reduces to fixed logic. Powers of two are plain bit slices.
    always_comb begin
        face = 8'd1;
        case (die_e'(die_select))
            DIE_D4:  face = {6'd0, lfsr[1:0]} + 8'd1;
            DIE_D6:  face = 8'(lfsr % 16'd6) + 8'd1;
            DIE_D8:  face = {5'd0, lfsr[2:0]} + 8'd1;
            DIE_D20: face = 8'(lfsr % 16'd20) + 8'd1;
            default: face = 8'd1;
        endcase
    end

    // State: the LFSR runs every clock, the edge detector follows `roll`, and
    // the output updates only on a roll event.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst_n) begin
            lfsr          <= SEED;
            // Tracking `roll` during reset means a level that is already high
            // when reset ends does not count as a roll.
            roll_q        <= roll;
            rolled_number <= 8'd1;
        end else begin
            lfsr   <= lfsr_next;
            roll_q <= roll;
            if (roll_event) begin
                rolled_number <= face;
            end
        end
    end

endmodule

// File: tb/tb_dice_roller.sv
// Testbench for dice_roller.
// A reference model predicts each roll from the LFSR sequence and the die
// rules and queues the expected face; a monitor on the falling edge pops and
// compares, and checks that the output holds between rolls.
module tb_dice_roller;

    logic       clk;
    logic       rst_n;
    logic [1:0] die_select;
    logic       roll;
    logic [7:0] rolled_number;

    dice_roller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .die_select    (die_select),
        .roll          (roll),
        .rolled_number (rolled_number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected within %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int val;
        int n;
    } exp_t;

    exp_t sb[$];
    int   run1[$];
    int   run2[$];
    bit   rec1 = 0;
    bit   rec2 = 0;

    int  m_lfsr   = 0;
    bit  m_roll_q = 0;
    bit  m_evt    = 0;
    bit  m_rst    = 0;

    function automatic int sides(input logic [1:0] sel);
        case (sel)
            2'd0:    return 4;
            2'd1:    return 6;
            2'd2:    return 8;
            default: return 20;
        endcase
    endfunction

    // One LFSR step with plain arithmetic: halve, fold in the mask when odd.
    function automatic int lfsr_step(input int x);
        if (x == 0) return 'hACE1;
        if (x % 2 == 1) return (x / 2) ^ 'hB400;
        return x / 2;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        m_evt = 0;
        m_rst = 0;
        if (rst_n === 1'b1) begin
            m_lfsr   = 'hACE1;
            m_roll_q = roll;
            m_rst    = 1;
            sb.delete();
        end else begin
            if (roll && !m_roll_q) begin
                e.n   = sides(die_select);
                e.val = (m_lfsr % e.n) + 1;
                sb.push_back(e);
                m_evt = 1;
                if (rec1) run1.push_back(e.val);
            end
            m_roll_q = roll;
            m_lfsr   = lfsr_step(m_lfsr);
        end
    end

    // ---------------- monitor ----------------
    bit armed   = 0;
    int cur_exp = 1;
    bit hist_en = 0;
    int hist20[21];
    int hist4[5];

    always @(negedge clk) begin
        exp_t e;
        if (m_rst) begin
            armed   = 1;
            cur_exp = 1;
            check("reset_value", int'(rolled_number), 1);
        end else if (armed) begin
            if (m_evt) begin
                if (sb.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check("roll_value", int'(rolled_number), e.val);
                    check_range("roll_range", int'(rolled_number), 1, e.n);
                    cur_exp = e.val;
                    if (hist_en && e.n == 20 && rolled_number >= 1 && rolled_number <= 20)
                        hist20[rolled_number]++;
                    if (hist_en && e.n == 4 && rolled_number >= 1 && rolled_number <= 4)
                        hist4[rolled_number]++;
                    if (rec2) run2.push_back(int'(rolled_number));
                end
            end else begin
                check("hold", int'(rolled_number), cur_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [1:0] sel, input int gap);
        @(negedge clk);
        die_select = sel;
        roll       = 1'b1;
        @(negedge clk);
        roll = 1'b0;
        cycles(gap - 1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(n);
        rst_n = 1'b0;
    endtask

    int det_gap[40];
    int det_sel[40];

    initial begin
        int saved;
        int changes;
        int prev;

        rst_n      = 1'b1;
        roll       = 1'b0;
        die_select = 2'd0;
        foreach (hist20[i]) hist20[i] = 0;
        foreach (hist4[i]) hist4[i] = 0;

        // Reset, then idle with roll low: output stays at 1.
        do_reset(2);
        cycles(50);
        check("reset_idle_50", int'(rolled_number), 1);

        // Range sweep per die, with distribution histograms for d4 and d20.
        hist_en = 1;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 1000; k++) begin
                pulse(2'(s), int'($urandom_range(1, 3)));
            end
        end
        hist_en = 0;
        cycles(2);
        for (int f = 1; f <= 20; f++) check_range($sformatf("d20_face_%0d", f), hist20[f], 20, 80);
        for (int f = 1; f <= 4; f++) check_range($sformatf("d4_face_%0d", f), hist4[f], 200, 300);

        // A level held high for 100 clocks gives at most one update.
        @(negedge clk);
        die_select = 2'd3;
        roll       = 1'b1;
        prev       = int'(rolled_number);
        changes    = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (int'(rolled_number) != prev) changes++;
            prev = int'(rolled_number);
        end
        check_range("edge_only_changes", changes, 0, 1);
        @(negedge clk);
        roll = 1'b0;
        cycles(3);

        // Switching the die without rolling leaves the held result alone.
        pulse(2'd3, 2);
        saved = cur_exp;
        @(negedge clk);
        die_select = 2'd0;
        cycles(10);
        check("hold_on_select_change", int'(rolled_number), saved);
        pulse(2'd0, 2);
        check_range("d4_after_switch", int'(rolled_number), 1, 4);

        // Back-to-back minimum-rate rolls with a change of die on the event.
        for (int k = 0; k < 20; k++) pulse(2'($urandom_range(0, 3)), 1);
        cycles(2);

        // Reset asserted while roll is high: output returns to 1 and no
        // event is seen when reset ends with roll still high.
        @(negedge clk);
        roll = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        rst_n = 1'b0;
        cycles(5);
        check("reset_with_roll_high", int'(rolled_number), 1);
        roll = 1'b0;
        cycles(2);

        // Determinism: identical timing after reset gives the same sequence.
        foreach (det_gap[i]) begin
            det_gap[i] = int'($urandom_range(1, 4));
            det_sel[i] = int'($urandom_range(0, 3));
        end
        do_reset(1);
        rec1 = 1;
        foreach (det_gap[i]) pulse(2'(det_sel[i]), det_gap[i]);
        rec1 = 0;
        cycles(3);
        do_reset(1);
        rec2 = 1;
        foreach (det_gap[i]) pulse(2'(det_sel[i]), det_gap[i]);
        cycles(2);
        rec2 = 0;
        check("determinism_count", run2.size(), run1.size());
        for (int i = 0; i < run1.size() && i < run2.size(); i++)
            check($sformatf("determinism_%0d", i), run2[i], run1[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
